// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection with branch/jump/stall/halt priority and deferred jump
module pc_sequencer (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [31:0] current_pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        halt_req,
    output logic [1:0]  pc_inc,
    output logic [31:0] next_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        halted,
    output logic        redirect_pending,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] INC_NORMAL = 2'b00;
    localparam logic [1:0] INC_HOLD   = 2'b01;
    localparam logic [1:0] INC_JUMP   = 2'b10;
    localparam logic [1:0] INC_STOP   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic [31:0] pc_plus_one;
    logic [31:0] stall_cycles_inc;

    assign pc_plus_one      = current_pc + 32'd1;
    assign stall_cycles_inc = (stall_cycles_q == 32'hFFFF_FFFF) ? stall_cycles_q
                                                                 : stall_cycles_q + 32'd1;

    always_comb begin
        pc_inc           = INC_NORMAL;
        next_pc          = pc_plus_one;
        flush_if         = 1'b0;
        flush_id         = 1'b0;
        state_d          = ST_RUN;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        stall_cycles_d   = stall_cycles_q;

        if (!clr_n) begin
            pending_d        = 1'b0;
            pending_target_d = 32'd0;
            stall_cycles_d   = 32'd0;
        end else if (state_q == ST_HALT) begin
            pc_inc  = INC_STOP;
            next_pc = current_pc;
            state_d = ST_HALT;
        end else if (halt_req) begin
            pc_inc  = INC_STOP;
            next_pc = current_pc;
            state_d = ST_HALT;
        end else if (br_taken) begin
            // A resolved branch outranks both the stall and any deferred jump.
            pc_inc    = INC_HOLD;
            next_pc   = br_target;
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            pending_d = 1'b0;
        end else if (pending_q && !stall) begin
            pc_inc    = INC_JUMP;
            next_pc   = pending_target_q;
            flush_if  = 1'b1;
            pending_d = 1'b0;
        end else if (stall) begin
            pc_inc         = INC_HOLD;
            next_pc        = current_pc;
            state_d        = ST_HOLD;
            stall_cycles_d = stall_cycles_inc;
            // The first jump seen during a stall wins; later ones are dropped.
            if (jmp_valid && !pending_q) begin
                pending_d        = 1'b1;
                pending_target_d = jmp_target;
            end
        end else if (jmp_valid) begin
            pc_inc   = INC_JUMP;
            next_pc  = jmp_target;
            flush_if = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q          <= ST_RUN;
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
            stall_cycles_q   <= 32'd0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
            stall_cycles_q   <= stall_cycles_d;
        end
    end

    assign halted           = clr_n && (state_q == ST_HALT);
    assign redirect_pending = pending_q;
    assign stall_cycles     = stall_cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        clr_n;
    logic [31:0] current_pc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        halt_req;
    logic [1:0]  pc_inc;
    logic [31:0] next_pc;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic        redirect_pending;
    logic [31:0] stall_cycles;

    pc_sequencer dut (
        .clk              (clk),
        .clr_n            (clr_n),
        .current_pc       (current_pc),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .halt_req         (halt_req),
        .pc_inc           (pc_inc),
        .next_pc          (next_pc),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .halted           (halted),
        .redirect_pending (redirect_pending),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr_n;
        logic [31:0] pc;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jv;
        logic [31:0] jt;
        logic        halt;
        logic [1:0]  e_inc;
        logic [31:0] e_npc;
        logic        e_fif;
        logic        e_fid;
        logic        e_halted;
        logic        e_rp;
        logic [31:0] e_sc;
    } vec_t;

    typedef struct {
        logic [1:0]  inc;
        logic [31:0] npc;
        logic        fif;
        logic        fid;
        logic        hlt;
        logic        rp;
        logic [31:0] sc;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   step;

    function automatic vec_t mk(logic c, logic [31:0] pc, logic st, logic br, logic [31:0] brt,
                                logic jv, logic [31:0] jt, logic h, logic [1:0] inc,
                                logic [31:0] npc, logic fif, logic fid, logic hl, logic rp,
                                logic [31:0] sc);
        vec_t v;
        v.clr_n = c;   v.pc = pc;     v.stall = st;  v.br = br;   v.brt = brt;
        v.jv = jv;     v.jt = jt;     v.halt = h;    v.e_inc = inc; v.e_npc = npc;
        v.e_fif = fif; v.e_fid = fid; v.e_halted = hl; v.e_rp = rp; v.e_sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        clr_n      = v.clr_n;
        current_pc = v.pc;
        stall      = v.stall;
        br_taken   = v.br;
        br_target  = v.brt;
        jmp_valid  = v.jv;
        jmp_target = v.jt;
        halt_req   = v.halt;
        e.inc = v.e_inc; e.npc = v.e_npc; e.fif = v.e_fif; e.fid = v.e_fid;
        e.hlt = v.e_halted; e.rp = v.e_rp; e.sc = v.e_sc;
        exp_q.push_back(e);
        #2;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            chk("pc_inc",           {30'd0, pc_inc},            {30'd0, got.inc});
            chk("next_pc",          next_pc,                    got.npc);
            chk("flush_if",         {31'd0, flush_if},          {31'd0, got.fif});
            chk("flush_id",         {31'd0, flush_id},          {31'd0, got.fid});
            chk("halted",           {31'd0, halted},            {31'd0, got.hlt});
            chk("redirect_pending", {31'd0, redirect_pending},  {31'd0, got.rp});
            chk("stall_cycles",     stall_cycles,               got.sc);
        end
        step++;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        step    = 0;
        clr_n = 1'b0; current_pc = 32'h10; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        jmp_valid = 1'b0; jmp_target = 32'd0; halt_req = 1'b0;
        @(posedge clk);
        @(posedge clk);

        //           clr pc            st br brt     jv jt       h   inc    npc           fif fid hl rp sc
        tbl.push_back(mk(0, 32'h10,       0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h11,       0, 0, 0, 0, 32'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'h10,   0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h11,       0, 0, 0, 0, 32'd0));
        tbl.push_back(mk(1, 32'h20,       1, 0, 32'h0,  1, 32'h40,  0, 2'b01, 32'h20,       0, 0, 0, 0, 32'd0));
        tbl.push_back(mk(1, 32'h20,       1, 0, 32'h0,  0, 32'h0,   0, 2'b01, 32'h20,       0, 0, 0, 1, 32'd1));
        tbl.push_back(mk(1, 32'h20,       1, 0, 32'h0,  0, 32'h0,   0, 2'b01, 32'h20,       0, 0, 0, 1, 32'd2));
        tbl.push_back(mk(1, 32'h20,       0, 0, 32'h0,  0, 32'h0,   0, 2'b10, 32'h40,       1, 0, 0, 1, 32'd3));
        tbl.push_back(mk(1, 32'h40,       0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h41,       0, 0, 0, 0, 32'd3));
        tbl.push_back(mk(1, 32'h41,       1, 0, 32'h0,  1, 32'h50,  0, 2'b01, 32'h41,       0, 0, 0, 0, 32'd3));
        tbl.push_back(mk(1, 32'h41,       1, 0, 32'h0,  1, 32'h60,  0, 2'b01, 32'h41,       0, 0, 0, 1, 32'd4));
        tbl.push_back(mk(1, 32'h41,       0, 0, 32'h0,  0, 32'h0,   0, 2'b10, 32'h50,       1, 0, 0, 1, 32'd5));
        tbl.push_back(mk(1, 32'h50,       1, 0, 32'h0,  1, 32'h70,  0, 2'b01, 32'h50,       0, 0, 0, 0, 32'd5));
        tbl.push_back(mk(1, 32'h50,       1, 1, 32'h80, 0, 32'h0,   0, 2'b01, 32'h80,       1, 1, 0, 1, 32'd6));
        tbl.push_back(mk(1, 32'h80,       0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h81,       0, 0, 0, 0, 32'd6));
        tbl.push_back(mk(1, 32'h81,       0, 0, 32'h0,  1, 32'h100, 0, 2'b10, 32'h100,      1, 0, 0, 0, 32'd6));
        tbl.push_back(mk(1, 32'h100,      1, 0, 32'h0,  1, 32'h200, 0, 2'b01, 32'h100,      0, 0, 0, 0, 32'd6));
        tbl.push_back(mk(1, 32'h100,      0, 0, 32'h0,  1, 32'h300, 0, 2'b10, 32'h200,      1, 0, 0, 1, 32'd7));
        tbl.push_back(mk(1, 32'h200,      0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h201,      0, 0, 0, 0, 32'd7));
        tbl.push_back(mk(1, 32'hFFFF_FFFF,0, 0, 32'h0,  0, 32'h0,   0, 2'b00, 32'h0,        0, 0, 0, 0, 32'd7));
        tbl.push_back(mk(1, 32'h30,       1, 0, 32'h0,  1, 32'h70,  0, 2'b01, 32'h30,       0, 0, 0, 0, 32'd7));
        tbl.push_back(mk(1, 32'h30,       1, 1, 32'h80, 1, 32'h90,  1, 2'b11, 32'h30,       0, 0, 0, 1, 32'd8));

        foreach (tbl[i]) apply(tbl[i]);

        // Halted: every request must be ignored and the counter frozen.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] r;
            r = $urandom;
            apply(mk(1, 32'h30, r[0], r[1], r, 1'b1, ~r, r[2], 2'b11, 32'h30, 0, 0, 1, 1, 32'd8));
        end

        // One reset cycle out of HALT with a jump still pending.
        apply(mk(0, 32'h30, 1, 0, 32'h0, 1, 32'h5, 1, 2'b00, 32'h31, 0, 0, 0, 1, 32'd8));
        apply(mk(1, 32'h30, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h31, 0, 0, 0, 0, 32'd0));

        // Counter saturation from a forced near-full value.
        @(negedge clk);
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        apply(mk(1, 32'h5, 1, 0, 32'h0, 0, 32'h0, 0, 2'b01, 32'h5, 0, 0, 0, 0, 32'hFFFF_FFFE));
        apply(mk(1, 32'h5, 1, 0, 32'h0, 0, 32'h0, 0, 2'b01, 32'h5, 0, 0, 0, 0, 32'hFFFF_FFFF));
        apply(mk(1, 32'h5, 1, 0, 32'h0, 0, 32'h0, 0, 2'b01, 32'h5, 0, 0, 0, 0, 32'hFFFF_FFFF));
        apply(mk(1, 32'h5, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h6, 0, 0, 0, 0, 32'hFFFF_FFFF));

        if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
